// File: rtl/iter_add_sub.sv
// Iterative chunked adder/subtractor.
// Adds CHUNK bits per cycle, rippling the carry through a register, so a
// WIDTH-bit add/sub takes N = WIDTH/CHUNK cycles of CALC.
// Handshake: request side valid/ready, result side valid/ready.
module iter_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // already inverted in subtract mode
    logic             carry;
    logic [KW-1:0]    k;

    logic [31:0]      sh;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic             last;

    // Select chunk k of both operands and add it with the running carry
    always_comb begin
        sh        = 32'(k) * 32'(CHUNK);
        chunk_a   = CHUNK'(a_reg >> sh);
        chunk_b   = CHUNK'(b_reg >> sh);
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
        last      = (k == KW'(N - 1));
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            k       <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_reg   <= i_a;
                        b_reg   <= i_sub ? ~i_b : i_b;
                        // subtract is A + ~B + 1, a borrow-in cancels the +1
                        carry   <= i_c_in ^ i_sub;
                        k       <= '0;
                        o_sum   <= '0;
                        o_ready <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // o_sum was cleared on accept, so OR-ing the chunk in is enough
                    o_sum <= o_sum | (WIDTH'(chunk_sum[CHUNK-1:0]) << sh);
                    carry <= chunk_sum[CHUNK];
                    k     <= k + 1'b1;
                    if (last) begin
                        k       <= '0;
                        o_cout  <= chunk_sum[CHUNK];
                        o_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                   (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
